// File: rtl/cmp_pipe_param_pkg.sv
// rtl/cmp_pipe_param_pkg.sv - op encodings and result decode for the MDCLCG comparator
package mdclcg_cmp_pkg;

  typedef enum logic [2:0] {
    CMP_EQ = 3'd0,
    CMP_NE = 3'd1,
    CMP_LT = 3'd2,
    CMP_LE = 3'd3,
    CMP_GT = 3'd4,
    CMP_GE = 3'd5
  } cmp_op_e;

  // Reserved encodings (6, 7) always evaluate false.
  function automatic logic cmp_decode(input logic [2:0] op, input logic gt, input logic eq);
    case (op)
      CMP_EQ:  return eq;
      CMP_NE:  return !eq;
      CMP_LT:  return !gt && !eq;
      CMP_LE:  return !gt;
      CMP_GT:  return gt;
      CMP_GE:  return gt || eq;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cmp_pipe_param_if.sv
// rtl/cmp_pipe_param_if.sv - operand/result handshake bundle for the pipelined comparator
interface cmp_pipe_param_if #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             is_signed;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic             result;
  logic             gt;
  logic             eq;
  logic [TAG_W-1:0] tag_out;

  modport master (
    output in_valid, a, b, op, is_signed, tag_in, out_ready,
    input  in_ready, out_valid, result, gt, eq, tag_out
  );

  modport slave (
    input  in_valid, a, b, op, is_signed, tag_in, out_ready,
    output in_ready, out_valid, result, gt, eq, tag_out
  );
endinterface

// File: rtl/cmp_pipe_param_chunk_stage.sv
// rtl/cmp_pipe_param_chunk_stage.sv - one MSB-first chunk step of the magnitude compare
module cmp_chunk_stage #(
  parameter int CHUNK = 16
) (
  input  logic             gt_in,
  input  logic             eq_in,
  input  logic [CHUNK-1:0] a_chunk,
  input  logic [CHUNK-1:0] b_chunk,
  output logic             gt_out,
  output logic             eq_out
);

  // Once a higher chunk has decided, lower chunks cannot change the verdict.
  always_comb begin
    gt_out = gt_in;
    eq_out = eq_in;
    if (eq_in) begin
      gt_out = (a_chunk > b_chunk);
      eq_out = (a_chunk == b_chunk);
    end
  end

endmodule

// File: rtl/cmp_pipe_param.sv
// rtl/cmp_pipe_param.sv - pipelined parametrised magnitude/equality comparator with back-pressure
module cmp_pipe_param
  import mdclcg_cmp_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4,
  parameter int TAG_W  = 8
) (
  input logic             clk,
  input logic             rst_n,
  cmp_pipe_param_if.slave bus
);

  localparam int CHUNK   = WIDTH / STAGES;
  localparam int REM_TOT = CHUNK * STAGES * (STAGES - 1) / 2;
  localparam int REM_W   = (REM_TOT > 0) ? REM_TOT : 1;
  localparam int OPN     = (STAGES > 1) ? STAGES - 1 : 1;

  // Unconsumed operand bits of every stage are packed into one flat vector.
  function automatic int rem_off(input int k);
    return CHUNK * (k * (STAGES - 1) - (k * (k - 1)) / 2);
  endfunction

  logic                adv;
  logic [WIDTH-1:0]    a_adj, b_adj;
  logic [STAGES-1:0]   vld_q, vld_d, vld_sh;
  logic [STAGES-1:0]   gt_q, gt_d, eq_q, eq_d;
  logic [STAGES-1:0]   gt_st, eq_st;
  logic [2:0]          op_st [STAGES];
  logic [2:0]          op_q  [OPN];
  logic [2:0]          op_d  [OPN];
  logic [TAG_W-1:0]    tag_st [STAGES];
  logic [TAG_W-1:0]    tag_q  [STAGES];
  logic [TAG_W-1:0]    tag_d  [STAGES];
  logic [REM_W-1:0]    rem_a, rem_b;
  logic [REM_W-1:0]    rem_a_q, rem_a_d, rem_b_q, rem_b_d;
  logic                res_q, res_d;

  assign adv          = !vld_q[STAGES-1] || bus.out_ready;
  assign bus.in_ready = adv;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  always_comb begin
    a_adj = bus.a;
    b_adj = bus.b;
    if (bus.is_signed) begin
      a_adj[WIDTH-1] = ~bus.a[WIDTH-1];
      b_adj[WIDTH-1] = ~bus.b[WIDTH-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IW = (STAGES - k) * CHUNK;
    logic [IW-1:0] a_cur, b_cur;
    logic          gt_cur, eq_cur;

    if (k == 0) begin : g_head
      assign a_cur     = a_adj;
      assign b_cur     = b_adj;
      assign gt_cur    = 1'b0;
      assign eq_cur    = 1'b1;
      assign op_st[k]  = bus.op;
      assign tag_st[k] = bus.tag_in;
    end else begin : g_body
      assign a_cur     = rem_a_q[rem_off(k-1) +: IW];
      assign b_cur     = rem_b_q[rem_off(k-1) +: IW];
      assign gt_cur    = gt_q[k-1];
      assign eq_cur    = eq_q[k-1];
      assign op_st[k]  = op_q[k-1];
      assign tag_st[k] = tag_q[k-1];
    end

    cmp_chunk_stage #(.CHUNK(CHUNK)) u_chunk (
      .gt_in   (gt_cur),
      .eq_in   (eq_cur),
      .a_chunk (a_cur[IW-1 -: CHUNK]),
      .b_chunk (b_cur[IW-1 -: CHUNK]),
      .gt_out  (gt_st[k]),
      .eq_out  (eq_st[k])
    );

    if (IW > CHUNK) begin : g_carry
      assign rem_a[rem_off(k) +: IW-CHUNK] = a_cur[IW-CHUNK-1:0];
      assign rem_b[rem_off(k) +: IW-CHUNK] = b_cur[IW-CHUNK-1:0];
    end
  end

  if (REM_TOT == 0) begin : g_norem
    assign rem_a = '0;
    assign rem_b = '0;
  end

  // A single advance enable freezes the whole pipe, bubbles included.
  always_comb begin
    vld_sh    = vld_q << 1;
    vld_sh[0] = bus.in_valid;
    vld_d     = adv ? vld_sh : vld_q;
    gt_d      = adv ? gt_st  : gt_q;
    eq_d      = adv ? eq_st  : eq_q;
    rem_a_d   = adv ? rem_a  : rem_a_q;
    rem_b_d   = adv ? rem_b  : rem_b_q;
    res_d     = adv ? cmp_decode(op_st[STAGES-1], gt_st[STAGES-1], eq_st[STAGES-1]) : res_q;
    for (int k = 0; k < OPN; k++) begin
      op_d[k] = adv ? op_st[k] : op_q[k];
    end
    for (int k = 0; k < STAGES; k++) begin
      tag_d[k] = adv ? tag_st[k] : tag_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      gt_q    <= '0;
      eq_q    <= '0;
      rem_a_q <= '0;
      rem_b_q <= '0;
      res_q   <= 1'b0;
      for (int k = 0; k < OPN; k++) begin
        op_q[k] <= '0;
      end
      for (int k = 0; k < STAGES; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      vld_q   <= vld_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      rem_a_q <= rem_a_d;
      rem_b_q <= rem_b_d;
      res_q   <= res_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
    end
  end

  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.result    = res_q;
  assign bus.gt        = gt_q[STAGES-1];
  assign bus.eq        = eq_q[STAGES-1];
  assign bus.tag_out   = tag_q[STAGES-1];

endmodule

// File: tb/tb_cmp_pipe_param.sv
// tb/tb_cmp_pipe_param.sv - directed and swept checks of cmp_pipe_param across three parameter sets
module tb_cmp_pipe_param;
  import mdclcg_cmp_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cmp_pipe_param_if #(.WIDTH(64), .TAG_W(8)) b64 ();
  cmp_pipe_param_if #(.WIDTH(32), .TAG_W(8)) b32 ();
  cmp_pipe_param_if #(.WIDTH(48), .TAG_W(8)) b48 ();

  cmp_pipe_param #(.WIDTH(64), .STAGES(4), .TAG_W(8)) u64 (.clk(clk), .rst_n(rst_n), .bus(b64));
  cmp_pipe_param #(.WIDTH(32), .STAGES(1), .TAG_W(8)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  cmp_pipe_param #(.WIDTH(48), .STAGES(3), .TAG_W(8)) u48 (.clk(clk), .rst_n(rst_n), .bus(b48));

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  op;
    logic        sg;
    logic [7:0]  tag;
    logic        res;
    logic        gt;
    logic        eq;
  } vec_t;

  vec_t tbl [12];

  localparam int N = 10000;
  logic [10:0] e32 [N];
  logic [10:0] e48 [N];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent reference: sign-extend to 65 bits and use native compares.
  function automatic logic [2:0] model(input logic [63:0] a, input logic [63:0] b,
                                       input logic [2:0] op, input logic sg, input int w);
    logic signed [64:0] xa, xb;
    logic lt, eqv, gtv, r;
    xa = {1'b0, a};
    xb = {1'b0, b};
    if (sg && a[w-1]) xa = xa | ({65{1'b1}} << w);
    if (sg && b[w-1]) xb = xb | ({65{1'b1}} << w);
    lt  = xa < xb;
    eqv = xa == xb;
    gtv = xa > xb;
    case (op)
      3'd0:    r = eqv;
      3'd1:    r = !eqv;
      3'd2:    r = lt;
      3'd3:    r = lt || eqv;
      3'd4:    r = gtv;
      3'd5:    r = !lt;
      default: r = 1'b0;
    endcase
    return {r, gtv, eqv};
  endfunction

  task automatic send64(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    b64.a = v.a; b64.b = v.b; b64.op = v.op; b64.is_signed = v.sg;
    b64.tag_in = v.tag; b64.in_valid = 1'b1; b64.out_ready = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      b64.in_valid = 1'b0;
    end while (!b64.out_valid && lat < 20);
    chk($sformatf("v%0d_latency", idx), lat, 4);
    chk($sformatf("v%0d_result", idx), b64.result, v.res);
    chk($sformatf("v%0d_gt", idx), b64.gt, v.gt);
    chk($sformatf("v%0d_eq", idx), b64.eq, v.eq);
    chk($sformatf("v%0d_tag", idx), b64.tag_out, v.tag);
  endtask

  initial begin
    int rx[$];
    int nt, stall_left, cyc;
    bit stalled, seen;
    logic [63:0] ra, rb;
    logic [2:0] rop;
    logic rsg;
    int mode;

    tbl[0]  = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, CMP_GE, 1'b0, 8'h10, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, CMP_GE, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, CMP_EQ, 1'b0, 8'h12, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{64'h0, 64'h0, CMP_LT, 1'b0, 8'h13, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{64'h1, 64'h0, CMP_NE, 1'b0, 8'h14, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{64'h1234_5678_9ABC_DEF1, 64'h1234_5678_9ABC_DEF0, CMP_GT, 1'b0, 8'h15, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{64'h5, 64'h9, CMP_LE, 1'b0, 8'h16, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, CMP_LT, 1'b1, 8'h17, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, CMP_LT, 1'b0, 8'h18, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd6, 1'b0, 8'h19, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{64'h0, 64'h1, CMP_GT, 1'b0, 8'h1A, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{64'h2, 64'h2, CMP_GE, 1'b1, 8'h1B, 1'b1, 1'b0, 1'b1};

    b64.in_valid = 0; b64.a = 0; b64.b = 0; b64.op = 0; b64.is_signed = 0; b64.tag_in = 0; b64.out_ready = 1;
    b32.in_valid = 0; b32.a = 0; b32.b = 0; b32.op = 0; b32.is_signed = 0; b32.tag_in = 0; b32.out_ready = 1;
    b48.in_valid = 0; b48.a = 0; b48.b = 0; b48.op = 0; b48.is_signed = 0; b48.tag_in = 0; b48.out_ready = 1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", b64.out_valid, 0);
    chk("rst_result", b64.result, 0);
    chk("rst_gt", b64.gt, 0);
    chk("rst_eq", b64.eq, 0);
    chk("rst_tag", b64.tag_out, 0);
    chk("rst_in_ready", b64.in_ready, 1);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) send64(tbl[i], i);

    // Back-pressure: 3-cycle stall while tag 2 sits on the outputs
    nt = 0; stall_left = 0; cyc = 0; stalled = 0;
    while (rx.size() < 8 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (b64.out_valid && b64.tag_out == 8'd2 && !stalled) begin
        stalled = 1;
        stall_left = 3;
      end
      b64.out_ready = (stall_left == 0);
      #1;
      if (!b64.out_ready) begin
        chk("bp_in_ready", b64.in_ready, 0);
        chk("bp_hold_tag", b64.tag_out, 2);
        chk("bp_hold_valid", b64.out_valid, 1);
        stall_left--;
      end
      if (b64.out_valid && b64.out_ready) begin
        chk($sformatf("bp_result_t%0d", b64.tag_out), b64.result, (b64.tag_out >= 8'd3));
        rx.push_back(int'(b64.tag_out));
      end
      b64.in_valid = (nt < 8); b64.tag_in = nt[7:0]; b64.a = 64'(nt); b64.b = 64'd3;
      b64.op = CMP_GE; b64.is_signed = 1'b0;
      #1;
      if (b64.in_valid && b64.in_ready) nt++;
    end
    b64.in_valid = 1'b0;
    b64.out_ready = 1'b1;
    chk("bp_count", rx.size(), 8);
    chk("bp_cycles", cyc, 15);
    for (int i = 0; i < rx.size() && i < 8; i++) chk($sformatf("bp_order_%0d", i), rx[i], i);

    // Reset mid-flight
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      b64.a = 64'h0; b64.b = 64'h0; b64.op = CMP_EQ; b64.is_signed = 0;
      b64.tag_in = 8'h20 + 8'(i); b64.in_valid = 1'b1;
      @(negedge clk);
    end
    b64.in_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("mid_pre_valid", b64.out_valid, 1);
    chk("mid_pre_tag", b64.tag_out, 8'h20);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", b64.out_valid, 0);
    chk("mid_rst_tag", b64.tag_out, 0);
    #3;
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (b64.out_valid) seen = 1;
    end
    chk("mid_no_ghost", seen, 0);
    send64(tbl[5], 50);

    // Random sweep on the 32/1 and 48/3 instances with continuous flow
    for (int i = 0; i < N + 4; i++) begin
      @(negedge clk);
      if (i >= 1 && i - 1 < N)
        chk($sformatf("sw32_%0d", i - 1), {b32.out_valid, b32.result, b32.gt, b32.eq, b32.tag_out}, {1'b1, e32[i-1]});
      else if (i == 0)
        chk("sw32_idle", b32.out_valid, 0);
      if (i >= 3 && i - 3 < N)
        chk($sformatf("sw48_%0d", i - 3), {b48.out_valid, b48.result, b48.gt, b48.eq, b48.tag_out}, {1'b1, e48[i-3]});
      else if (i < 3)
        chk($sformatf("sw48_idle_%0d", i), b48.out_valid, 0);
      if (i < N) begin
        ra = {$urandom, $urandom};
        mode = $urandom_range(0, 3);
        case (mode)
          0: rb = {$urandom, $urandom};
          1: rb = ra;
          2: rb = ra ^ (64'h1 << $urandom_range(0, 31));
          default: rb = ra ^ 64'h0000_8000_8000_0000;
        endcase
        rop = 3'($urandom_range(0, 7));
        rsg = 1'($urandom_range(0, 1));
        b32.a = ra[31:0]; b32.b = rb[31:0]; b32.op = rop; b32.is_signed = rsg;
        b32.tag_in = i[7:0]; b32.in_valid = 1'b1;
        b48.a = ra[47:0]; b48.b = rb[47:0]; b48.op = rop; b48.is_signed = rsg;
        b48.tag_in = i[7:0]; b48.in_valid = 1'b1;
        e32[i] = {model({32'h0, ra[31:0]}, {32'h0, rb[31:0]}, rop, rsg, 32), i[7:0]};
        e48[i] = {model({16'h0, ra[47:0]}, {16'h0, rb[47:0]}, rop, rsg, 48), i[7:0]};
      end else begin
        b32.in_valid = 1'b0;
        b48.in_valid = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmp_pipe_param.md
Name: cmp_pipe_param

Overview:
- Parametrised, pipelined magnitude/equality comparator for the MDCLCG datapath.
- Successor to the fixed 64-bit single-output "a >= b" comparator. Used for modulus-reduction decisions (x >= m) and seed/range checks.
- Adds width and depth parameters, runtime op select (EQ/NE/LT/LE/GT/GE), signed mode, a tag passthrough and a valid/ready handshake with back-pressure.
- Sits between the LCG multiply/add stages and the conditional-subtract stage.

Parameters:
- WIDTH, 64, operand width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth. Each stage compares one CHUNK = WIDTH/STAGES slice, processing from MSB to LSB.
- TAG_W, 8, width of the sideband tag carried alongside each operand pair.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: operand pair is present.
- in_ready, output, 1: block accepts the pair this cycle.
- a, input, WIDTH: left operand.
- b, input, WIDTH: right operand.
- op, input, 3: comparison select, encoded per the package.
- is_signed, input, 1: 1 = two's-complement compare; 0 = unsigned compare.
- tag_in, input, TAG_W: sideband tag, passed through unchanged.
- out_valid, output, 1: result is present.
- out_ready, input, 1: downstream accepts the result.
- result, output, 1: boolean value of (a op b).
- gt, output, 1: raw a > b under the selected signedness.
- eq, output, 1: raw a == b.
- tag_out, output, TAG_W: tag aligned with result.

Behaviour:
- One clock domain; reset is asynchronous, active-low.
- While rst_n = 0:
  - all stage valid bits clear, so out_valid = 0;
  - result, gt, eq and tag_out are 0;
  - in_ready = 1 once the block is out of reset.
- Transfer rules:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
- Global stall: adv = !out_valid | out_ready, and in_ready = adv.
  - When adv = 0, every stage register holds, including data, flags and tag.
  - A bubble stage does not collapse under stall. Throughput is 1 pair/cycle when out_ready is held high.
- Latency: an accepted pair appears on the outputs exactly STAGES cycles later, with no stall cycles in between. Each stall cycle adds one cycle.
- Signed mode, applied at stage 0 entry: if is_signed, invert the MSB of both a and b. The signed compare then reduces to an unsigned compare.
- Stage k (k = 0..STAGES-1) works on chunk index STAGES-1-k, bits [(STAGES-k)*CHUNK-1 : (STAGES-1-k)*CHUNK]:
  - if eq_acc = 1: gt_acc <= (a_chunk > b_chunk), eq_acc <= (a_chunk == b_chunk);
  - otherwise gt_acc and eq_acc hold their values.
  - Stage 0 starts from gt_acc = 0, eq_acc = 1.
  - Operand bits not yet consumed, op and tag travel with the stage registers. Consumed bits are dropped.
- The final stage decodes op:
  - EQ = eq
  - NE = !eq
  - LT = !gt & !eq
  - LE = !gt
  - GT = gt
  - GE = gt | eq
  - Reserved codes (110, 111) give result = 0.
- gt and eq are always driven, regardless of op.
- Outputs are registered and stable while out_valid & !out_ready.
- Boundary conditions:
  - a == b == 0 and a == b == all-ones must give eq = 1.
  - Stall on the same cycle as a new input: the input is not accepted, because in_ready = 0.
  - Reset mid-stream drops every in-flight pair; no partial result is emitted.
  - STAGES = 1 degenerates to a single registered full-width compare with latency 1.

Decomposition:
- Package mdclcg_cmp_pkg holds:
  - op encodings: CMP_EQ = 3'd0, CMP_NE = 3'd1, CMP_LT = 3'd2, CMP_LE = 3'd3, CMP_GT = 3'd4, CMP_GE = 3'd5;
  - a function that decodes op from (gt, eq).
- One sub-module, cmp_chunk_stage, parametrised by CHUNK. It takes the incoming accumulator and chunk and produces the next gt/eq. It is instantiated STAGES times in a generate loop.
- Pipeline registers and the handshake live in cmp_pipe_param.

Test Plan:
- Unsigned GE, default params:
  - a = 64'h8000_0000_0000_0000, b = 64'h7FFF_FFFF_FFFF_FFFF, op = GE, is_signed = 0 -> after 4 cycles: result = 1, gt = 1, eq = 0.
  - Same operands with is_signed = 1 -> result = 0, gt = 0.
- Equality:
  - a = b = 64'hFFFF_FFFF_FFFF_FFFF, op = EQ -> result = 1, eq = 1.
  - a = b = 0, op = LT -> result = 0.
  - a = 1, b = 0, op = NE -> result = 1.
- LSB-chunk decision: a = 64'h1234_5678_9ABC_DEF1, b = 64'h1234_5678_9ABC_DEF0, op = GT -> result = 1. This is decided only in the last stage.
- Back-pressure:
  - Stream 8 pairs with tags 0..7 and out_ready = 1.
  - Drop out_ready for 3 cycles after tag 2 appears -> tag_out sequence is exactly 0..7 with none lost or duplicated. in_ready = 0 during the stall. Outputs hold tag 2 for the duration of the stall.
- Reset mid-flight: accept 3 pairs, then pulse rst_n low asynchronously between clock edges -> out_valid = 0 immediately, no result is ever emitted for those pairs, and the next accepted pair has latency 4.
- Parameter sweep: WIDTH = 32, STAGES = 1 and WIDTH = 48, STAGES = 3, with 10k random (a, b, op, is_signed) vectors -> result matches the reference model and latency equals STAGES.
